// File: rtl/if_align_if.sv
// Fetch/decode-side signals of the instruction aligner.
// master drives fetch words, redirects and decode ready; slave is the aligner.
interface if_align_if #(
  parameter int unsigned XLEN = 64
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_data;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic            id_compressed;

  modport master (
    output redirect_valid, redirect_pc, fetch_valid, fetch_data, id_ready,
    input  fetch_ready, id_valid, id_inst, id_pc, id_compressed
  );

  modport slave (
    input  redirect_valid, redirect_pc, fetch_valid, fetch_data, id_ready,
    output fetch_ready, id_valid, id_inst, id_pc, id_compressed
  );
endinterface

// File: rtl/if_align.sv
// Instruction aligner: halfword queue turning fetch words into 16/32-bit instructions.
// Define IF_ALIGN_RVC_EN for compressed support; otherwise every instruction is 32-bit.
module if_align #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned HW_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  if_align_if.slave bus
);
  localparam int unsigned PW = $clog2(HW_DEPTH);
  localparam int unsigned CW = $clog2(HW_DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [15:0]     q [HW_DEPTH];
  ptr_t            head_q, tail_q;
  cnt_t            cnt_q;
  logic [XLEN-1:0] head_pc_q;

  logic [15:0] hw0, hw1;
  logic        is16, id_valid, fetch_ready, push, pop;
  logic [1:0]  push_n, pop_n;

  // Pointers wrap modulo HW_DEPTH, which need not be a power of two.
  function automatic ptr_t ptr_add(ptr_t p, logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    if (s >= (PW+1)'(HW_DEPTH)) s = s - (PW+1)'(HW_DEPTH);
    return s[PW-1:0];
  endfunction

  assign hw0 = q[head_q];
  assign hw1 = q[ptr_add(head_q, 2'd1)];

`ifdef IF_ALIGN_RVC_EN
  logic drop_low_q;
  assign is16   = (hw0[1:0] != 2'b11);
  assign push_n = drop_low_q ? 2'd1 : 2'd2;
`else
  assign is16   = 1'b0;
  assign push_n = 2'd2;
`endif

  assign pop_n       = is16 ? 2'd1 : 2'd2;
  assign id_valid    = (cnt_q >= CW'(pop_n));
  assign fetch_ready = (cnt_q <= CW'(HW_DEPTH - 2));
  assign push        = bus.fetch_valid & fetch_ready & ~bus.redirect_valid;
  assign pop         = id_valid & bus.id_ready & ~bus.redirect_valid;

  assign bus.fetch_ready   = fetch_ready;
  assign bus.id_valid      = id_valid;
  assign bus.id_inst       = !id_valid ? 32'h0 : (is16 ? {16'h0, hw0} : {hw1, hw0});
  assign bus.id_compressed = id_valid & is16;
  assign bus.id_pc         = head_pc_q;

  // Queue storage needs no reset: cnt gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
`ifdef IF_ALIGN_RVC_EN
      if (drop_low_q) begin
        q[tail_q] <= bus.fetch_data[31:16];
      end else begin
        q[tail_q]                   <= bus.fetch_data[15:0];
        q[ptr_add(tail_q, 2'd1)]    <= bus.fetch_data[31:16];
      end
`else
      q[tail_q]                <= bus.fetch_data[15:0];
      q[ptr_add(tail_q, 2'd1)] <= bus.fetch_data[31:16];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      head_pc_q <= '0;
`ifdef IF_ALIGN_RVC_EN
      drop_low_q <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      head_pc_q <= bus.redirect_pc;
`ifdef IF_ALIGN_RVC_EN
      // Fetch restarts at the enclosing word; skip its low half for a +2 target.
      drop_low_q <= bus.redirect_pc[1];
`endif
    end else begin
      if (push) begin
        tail_q <= ptr_add(tail_q, push_n);
`ifdef IF_ALIGN_RVC_EN
        drop_low_q <= 1'b0;
`endif
      end
      if (pop) begin
        head_q    <= ptr_add(head_q, pop_n);
        head_pc_q <= head_pc_q + XLEN'({pop_n, 1'b0});
      end
      cnt_q <= cnt_q + (push ? CW'(push_n) : '0) - (pop ? CW'(pop_n) : '0);
    end
  end
endmodule

// File: tb/tb_if_align.sv
// Scoreboard bench for if_align: expected instructions are queued at stimulus time
// and a negedge monitor compares every instruction the aligner hands to decode.
module tb_if_align;
  localparam int unsigned XLEN = 64;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        comp;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  if_align_if #(.XLEN(XLEN)) bus ();

  if_align #(.XLEN(XLEN), .HW_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_inst: got inst=%h pc=%h c=%b, required nothing",
                 bus.id_inst, bus.id_pc, bus.id_compressed);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.id_inst !== e.inst || bus.id_pc !== e.pc || bus.id_compressed !== e.comp) begin
          n_fail++;
          $display("FAIL inst_stream: got inst=%h pc=%h c=%b, required inst=%h pc=%h c=%b",
                   bus.id_inst, bus.id_pc, bus.id_compressed, e.inst, e.pc, e.comp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_inst(input logic [31:0] inst, input logic [63:0] pc, input logic comp);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    e.comp = comp;
    exp_q.push_back(e);
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // Holds the word until accepted; frees decode if the queue is full.
  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = w;
    while (!bus.fetch_ready && guard < 100) begin
      bus.id_ready = 1'b1;
      tick();
      guard++;
    end
    if (!bus.fetch_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_ready_timeout: got 0, required 1");
    end
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    bus.id_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    tick();
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] hws[$];
    logic [63:0] pc;
    logic [15:0] h, lo, hi;
    logic [31:0] w;
    int k;

    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.fetch_valid    = 1'b0;
    bus.fetch_data     = '0;
    bus.id_ready       = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_id_valid", 64'(bus.id_valid), 64'd0);
    check("reset_id_inst", 64'(bus.id_inst), 64'd0);
    check("reset_id_pc", bus.id_pc, 64'd0);
    check("reset_id_compressed", 64'(bus.id_compressed), 64'd0);
    check("reset_fetch_ready", 64'(bus.fetch_ready), 64'd1);

    // 1: single 32-bit instruction after a redirect
    redirect(64'h8000_0000);
    check("t1_empty_after_redirect", 64'(bus.id_valid), 64'd0);
    check("t1_pc_after_redirect", bus.id_pc, 64'h8000_0000);
    expect_inst(32'h0000_0513, 64'h8000_0000, 1'b0);
    send_word(32'h0000_0513);
    drain("t1_drain");

    // 2: two compressed instructions in one word
    redirect(64'h1000);
`ifdef IF_ALIGN_RVC_EN
    expect_inst(32'h0000_0505, 64'h1000, 1'b1);
    expect_inst(32'h0000_4505, 64'h1002, 1'b1);
`else
    expect_inst(32'h4505_0505, 64'h1000, 1'b0);
`endif
    send_word(32'h4505_0505);
    drain("t2_drain");

`ifdef IF_ALIGN_RVC_EN
    // 3: 32-bit instruction straddling two words, entered at a +2 target
    redirect(64'h2002);
    send_word(32'h0513_abcd);
    check("t3_straddle_wait", 64'(bus.id_valid), 64'd0);
    expect_inst(32'h0000_0513, 64'h2002, 1'b0);
    expect_inst(32'h0000_1234, 64'h2006, 1'b1);
    send_word(32'h1234_0000);
    drain("t3_drain");
`endif

    // 4: backpressure fills the queue and holds the head instruction
    redirect(64'h3000);
    bus.id_ready = 1'b0;
`ifdef IF_ALIGN_RVC_EN
    expect_inst(32'h0000_0505, 64'h3000, 1'b1);
    expect_inst(32'h0000_0513, 64'h3002, 1'b0);
    expect_inst(32'h0000_0001, 64'h3006, 1'b1);
`else
    expect_inst(32'h0513_0505, 64'h3000, 1'b0);
    expect_inst(32'h0001_0000, 64'h3004, 1'b0);
`endif
    send_word(32'h0513_0505);
    send_word(32'h0001_0000);
    check("t4_fetch_ready_full", 64'(bus.fetch_ready), 64'd0);
    repeat (3) tick();
    check("t4_hold_valid", 64'(bus.id_valid), 64'd1);
`ifdef IF_ALIGN_RVC_EN
    check("t4_hold_inst", 64'(bus.id_inst), 64'h0505);
    check("t4_hold_comp", 64'(bus.id_compressed), 64'd1);
`else
    check("t4_hold_inst", 64'(bus.id_inst), 64'h0513_0505);
    check("t4_hold_comp", 64'(bus.id_compressed), 64'd0);
`endif
    check("t4_hold_pc", bus.id_pc, 64'h3000);
    drain("t4_drain");
    check("t4_fetch_ready_back", 64'(bus.fetch_ready), 64'd1);

    // 5: redirect wins over a simultaneous push and pop
    redirect(64'h4000);
    bus.id_ready = 1'b0;
    send_word(32'h0000_0513);
    check("t5_setup_valid", 64'(bus.id_valid), 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h5000;
    bus.fetch_valid    = 1'b1;
    bus.fetch_data     = 32'hdead_beef;
    bus.id_ready       = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.fetch_valid    = 1'b0;
    check("t5_flushed_valid", 64'(bus.id_valid), 64'd0);
    check("t5_redirect_pc", bus.id_pc, 64'h5000);
    check("t5_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    expect_inst(32'h0000_0593, 64'h5000, 1'b0);
    send_word(32'h0000_0593);
    drain("t5_drain");

    // 6: long stream wrapping the queue with intermittent backpressure
    redirect(64'h6000);
`ifdef IF_ALIGN_RVC_EN
    pc = 64'h6000;
    k  = 0;
    while (hws.size() < 40) begin
      if (k % 2 == 0 || hws.size() > 38) begin
        h = 16'h0001 | 16'(k << 2);
        hws.push_back(h);
        expect_inst({16'h0, h}, pc, 1'b1);
        pc = pc + 2;
      end else begin
        lo = 16'h0003 | 16'(k << 2);
        hi = 16'ha000 + 16'(k);
        hws.push_back(lo);
        hws.push_back(hi);
        expect_inst({hi, lo}, pc, 1'b0);
        pc = pc + 4;
      end
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      bus.id_ready = (i % 4 != 3);
      send_word({hws[2*i+1], hws[2*i]});
    end
`else
    for (int i = 0; i < 20; i++) begin
      w = ((i % 2) == 0) ? (32'h0000_0013 | 32'(i << 7)) : (32'h0000_0001 | 32'(i << 7));
      expect_inst(w, 64'h6000 + 64'(4 * i), 1'b0);
      bus.id_ready = (i % 4 != 3);
      send_word(w);
    end
`endif
    drain("t6_drain");

    // 7: reset mid-operation discards queued data
    redirect(64'h7000);
    bus.id_ready = 1'b0;
    send_word(32'h0000_0513);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_reset_valid", 64'(bus.id_valid), 64'd0);
    check("t7_reset_pc", bus.id_pc, 64'd0);
    check("t7_reset_fetch_ready", 64'(bus.fetch_ready), 64'd1);
    bus.id_ready = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
